// File: rtl/wam_game_sequencer_if.sv
// wam_game_sequencer_if: controls and status exchanged between the whack-a-mole
// game sequencer and the rest of the top level.
//   master (top level / switches / light+keypad controllers) drives play, gamemode,
//   difficulty_sw, extended, light_on, light_off, light_pos, key_valid and key.
//   slave (sequencer) drives load_seed, start_game, game_over, difficulty_oh,
//   total_points, light_flicks, misses, time_left, max_hits
//   and best_score (only when BEST_SCORE_EN is defined).
interface wam_game_sequencer_if;
  logic       play;
  logic [3:0] gamemode;
  logic [3:0] difficulty_sw;
  logic       extended;
  logic       light_on;
  logic       light_off;
  logic [3:0] light_pos;
  logic       key_valid;
  logic [3:0] key;
  logic       load_seed;
  logic       start_game;
  logic       game_over;
  logic [3:0] difficulty_oh;
  logic [6:0] total_points;
  logic [6:0] light_flicks;
  logic [6:0] misses;
  logic [5:0] time_left;
  logic [6:0] max_hits;
`ifdef BEST_SCORE_EN
  logic [6:0] best_score;
`endif
  modport master (
    output play, gamemode, difficulty_sw, extended, light_on, light_off, light_pos, key_valid, key,
    input  load_seed, start_game, game_over, difficulty_oh, total_points, light_flicks, misses,
           time_left, max_hits
`ifdef BEST_SCORE_EN
    , input best_score
`endif
  );
  modport slave (
    input  play, gamemode, difficulty_sw, extended, light_on, light_off, light_pos, key_valid, key,
    output load_seed, start_game, game_over, difficulty_oh, total_points, light_flicks, misses,
           time_left, max_hits
`ifdef BEST_SCORE_EN
    , output best_score
`endif
  );
endinterface

// File: rtl/wam_game_sequencer.sv
// wam_game_sequencer: whack-a-mole game controller (SETUP/PLAY/GAMEOVER/RESTART),
// scoring, flick/miss counting, timed countdown and game-over decision.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   io_bus : wam_game_sequencer_if.slave (switch/controller inputs, game status outputs)
// Optional: define BEST_SCORE_EN to add io_bus.best_score, the best total_points seen
// at GAMEOVER entry since reset.
module wam_game_sequencer #(
  parameter int TICKS_PER_SEC  = 50_000_000,
  parameter int TIMED_SECS     = 60,
  parameter int HITS_PER_LEVEL = 5,
  parameter int NORMAL_MAX     = 25,
  parameter int EXTENDED_MAX   = 50
) (
  input logic                 clk,
  input logic                 reset,
  wam_game_sequencer_if.slave io_bus
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [1:0] S_SETUP = 2'd0, S_PLAY = 2'd1, S_GAMEOVER = 2'd2, S_RESTART = 2'd3;
  localparam logic [3:0] M_NORMAL = 4'b0001, M_TIMED = 4'b0010, M_DEATH = 4'b0100, M_LEVEL = 4'b1000;
  logic [1:0]    r_state, r_level;
  logic          r_play_d, r_load_seed, r_start_game, r_game_over, r_armed;
  logic [3:0]    r_mode;
  logic [6:0]    r_max, r_points, r_flicks, r_misses;
  logic [5:0]    r_time;
  logic [PW-1:0] r_presc;
  logic          w_edge, w_play, w_hit, w_off, w_miss, w_tick, w_end, w_latch, w_restart, w_level_up;
  logic          w_gm_ok, w_sw_ok;
  logic [1:0]    w_state_nx;
  logic [6:0]    w_points_nx, w_flicks_nx, w_misses_nx;
  assign w_edge    = io_bus.play & ~r_play_d;
  assign w_play    = r_state == S_PLAY;
  assign w_restart = r_state == S_RESTART;
  assign w_hit     = w_play & io_bus.key_valid & r_armed & (io_bus.key == io_bus.light_pos);
  assign w_off     = w_play & io_bus.light_off;
  assign w_miss    = w_off & r_armed & ~w_hit;
  assign w_tick    = w_play & (r_presc == PW'(TICKS_PER_SEC - 1));
  assign w_points_nx = (w_hit && r_points != 7'd99) ? r_points + 7'd1 : r_points;
  assign w_flicks_nx = (w_off && r_flicks != 7'd99) ? r_flicks + 7'd1 : r_flicks;
  assign w_misses_nx = (w_miss && r_misses != 7'd99) ? r_misses + 7'd1 : r_misses;
  // level advances on the hit that lands points on a multiple of HITS_PER_LEVEL
  assign w_level_up = w_hit && r_points != 7'd99 && r_level != 2'd3 &&
                      (int'(w_points_nx) % HITS_PER_LEVEL == 0);
  assign w_gm_ok = io_bus.gamemode != 4'd0 && (io_bus.gamemode & (io_bus.gamemode - 4'd1)) == 4'd0;
  assign w_sw_ok = io_bus.difficulty_sw != 4'd0 &&
                   (io_bus.difficulty_sw & (io_bus.difficulty_sw - 4'd1)) == 4'd0;
  assign w_end = w_play & (r_mode == M_TIMED ? r_time == 6'd0 :
                           r_mode == M_DEATH ? r_misses == 7'd1 : r_flicks == r_max);
  assign w_latch = (r_state == S_SETUP && w_edge) || w_restart;
  assign w_state_nx = r_state == S_SETUP    ? (w_edge ? S_PLAY : S_SETUP) :
                      r_state == S_PLAY     ? ((w_edge | w_end) ? S_GAMEOVER : S_PLAY) :
                      r_state == S_GAMEOVER ? (w_edge ? S_RESTART : S_GAMEOVER) : S_PLAY;
  assign io_bus.load_seed     = r_load_seed;
  assign io_bus.start_game    = r_start_game;
  assign io_bus.game_over     = r_game_over;
  assign io_bus.total_points  = r_points;
  assign io_bus.light_flicks  = r_flicks;
  assign io_bus.misses        = r_misses;
  assign io_bus.time_left     = r_time;
  assign io_bus.max_hits      = r_max;
  assign io_bus.difficulty_oh = r_mode == M_LEVEL ? 4'b0001 << r_level :
                                (w_sw_ok ? io_bus.difficulty_sw : 4'b0010);
  // r_play_d resets high so a play level present at reset release is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_SETUP;
      r_play_d     <= 1'b1;
      r_load_seed  <= 1'b1;
      r_start_game <= 1'b0;
      r_game_over  <= 1'b0;
      r_armed      <= 1'b0;
      r_mode       <= M_NORMAL;
      r_max        <= 7'(NORMAL_MAX);
      r_points     <= 7'd0;
      r_flicks     <= 7'd0;
      r_misses     <= 7'd0;
      r_time       <= 6'(TIMED_SECS);
      r_level      <= 2'd0;
      r_presc      <= '0;
    end else begin
      r_play_d     <= io_bus.play;
      r_state      <= w_state_nx;
      r_load_seed  <= w_state_nx == S_SETUP;
      r_start_game <= w_state_nx == S_PLAY;
      r_game_over  <= w_state_nx == S_GAMEOVER;
      if (w_latch) begin
        r_mode <= w_gm_ok ? io_bus.gamemode : M_NORMAL;
        r_max  <= io_bus.extended ? 7'(EXTENDED_MAX) : 7'(NORMAL_MAX);
      end
      if (w_restart) begin
        r_armed  <= 1'b0;
        r_points <= 7'd0;
        r_flicks <= 7'd0;
        r_misses <= 7'd0;
        r_time   <= 6'(TIMED_SECS);
        r_level  <= 2'd0;
        r_presc  <= '0;
      end else begin
        r_armed  <= (w_play & io_bus.light_on) | (r_armed & ~w_hit & ~w_off);
        r_points <= w_points_nx;
        r_flicks <= w_flicks_nx;
        r_misses <= w_misses_nx;
        if (w_play) r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick && r_time != 6'd0) r_time <= r_time - 6'd1;
        if (w_level_up) r_level <= r_level + 2'd1;
      end
    end
  end
`ifdef BEST_SCORE_EN
  logic [6:0] r_best;
  assign io_bus.best_score = r_best;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_best <= 7'd0;
    else if (w_play && w_state_nx == S_GAMEOVER && w_points_nx > r_best) r_best <= w_points_nx;
  end
`endif
endmodule

// File: tb/tb_wam_game_sequencer.sv
// tb_wam_game_sequencer: self-checking bench for wam_game_sequencer (TICKS_PER_SEC=4).
module tb_wam_game_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int m_points, m_flicks, m_misses, m_armed;
  typedef struct { int pts; int flk; int mis; } exp_t;
  exp_t sb[$];
  typedef struct { logic [3:0] sw; logic [3:0] exp; } dvec_t;
  dvec_t dv[7];
  wam_game_sequencer_if bus();
  wam_game_sequencer #(.TICKS_PER_SEC(4)) dut (.clk(clk), .reset(reset), .io_bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear();
    m_points = 0; m_flicks = 0; m_misses = 0; m_armed = 0;
  endtask
  task automatic ev(input bit on, input bit off, input bit kv, input logic [3:0] k,
                    input logic [3:0] pos, input bit live);
    exp_t e;
    bit hit;
    bus.light_on = on; bus.light_off = off; bus.key_valid = kv; bus.key = k; bus.light_pos = pos;
    if (live) begin
      hit = kv && m_armed != 0 && k == pos;
      if (hit && m_points < 99) m_points++;
      if (off && m_flicks < 99) m_flicks++;
      if (off && m_armed != 0 && !hit && m_misses < 99) m_misses++;
      m_armed = (on || (m_armed != 0 && !hit && !off)) ? 1 : 0;
    end
    sb.push_back('{m_points, m_flicks, m_misses});
    cyc();
    bus.light_on = 1'b0; bus.light_off = 1'b0; bus.key_valid = 1'b0;
    e = sb.pop_front();
    chk("total_points", int'(bus.total_points), e.pts);
    chk("light_flicks", int'(bus.light_flicks), e.flk);
    chk("misses", int'(bus.misses), e.mis);
  endtask
  task automatic lights(input int n_hit, input int n_miss);
    for (int i = 0; i < n_hit + n_miss; i++) begin
      ev(1, 0, 0, 0, 4'(i % 10), 1);
      if (i < n_hit) ev(0, 0, 1, 4'(i % 10), 4'(i % 10), 1);
      ev(0, 1, 0, 0, 4'(i % 10), 1);
    end
  endtask
  task automatic start_from_setup();
    bit ok = 0;
    bus.play = 1'b1;
    for (int i = 0; i < 2 && !ok; i++) begin
      cyc();
      ok = bus.start_game;
    end
    chk("start_latency", int'(ok), 1);
    cyc(); cyc();
    bus.play = 1'b0;
    cyc();
    chk("held_play_start", int'(bus.start_game), 1);
    chk("held_play_gameover", int'(bus.game_over), 0);
    chk("play_load_seed", int'(bus.load_seed), 0);
    model_clear();
  endtask
  task automatic abort_game();
    bus.play = 1'b1;
    cyc();
    bus.play = 1'b0;
    chk("abort_game_over", int'(bus.game_over), 1);
    chk("abort_start_game", int'(bus.start_game), 0);
  endtask
  task automatic restart(input logic [3:0] gm, input bit ext);
    bus.gamemode = gm; bus.extended = ext;
    bus.play = 1'b1;
    cyc();
    bus.play = 1'b0;
    chk("restart_start_game", int'(bus.start_game), 0);
    chk("restart_game_over", int'(bus.game_over), 0);
    chk("restart_load_seed", int'(bus.load_seed), 0);
    cyc();
    chk("restart_to_play", int'(bus.start_game), 1);
    chk("restart_points", int'(bus.total_points), 0);
    chk("restart_flicks", int'(bus.light_flicks), 0);
    chk("restart_misses", int'(bus.misses), 0);
    chk("restart_time", int'(bus.time_left), 60);
    chk("restart_max_hits", int'(bus.max_hits), ext ? 50 : 25);
    model_clear();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end
  initial begin
    int mp, mt, lvl;
    dv[0] = '{4'b0001, 4'b0001};
    dv[1] = '{4'b0010, 4'b0010};
    dv[2] = '{4'b0100, 4'b0100};
    dv[3] = '{4'b1000, 4'b1000};
    dv[4] = '{4'b0000, 4'b0010};
    dv[5] = '{4'b0011, 4'b0010};
    dv[6] = '{4'b1111, 4'b0010};
    bus.play = 1'b0; bus.gamemode = 4'b0001; bus.difficulty_sw = 4'b0000; bus.extended = 1'b0;
    bus.light_on = 1'b0; bus.light_off = 1'b0; bus.light_pos = 4'd0; bus.key_valid = 1'b0; bus.key = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset_load_seed", int'(bus.load_seed), 1);
    reset = 1'b1;
    cyc();
    chk("reset_load_seed", int'(bus.load_seed), 1);
    chk("reset_start_game", int'(bus.start_game), 0);
    chk("reset_game_over", int'(bus.game_over), 0);
    chk("reset_time_left", int'(bus.time_left), 60);
    chk("reset_points", int'(bus.total_points), 0);
    chk("reset_flicks", int'(bus.light_flicks), 0);
    chk("reset_misses", int'(bus.misses), 0);
    chk("reset_max_hits", int'(bus.max_hits), 25);
    for (int i = 0; i < 7; i++) begin
      bus.difficulty_sw = dv[i].sw;
      #1;
      chk("difficulty_passthrough", int'(bus.difficulty_oh), int'(dv[i].exp));
    end
    bus.difficulty_sw = 4'b0100;
    // setup-phase light events are ignored
    ev(1, 0, 0, 0, 4'd1, 0);
    ev(0, 1, 0, 0, 4'd1, 0);
    // normal game: 10 hits, 15 misses
    start_from_setup();
    lights(10, 15);
    chk("normal_not_over_yet", int'(bus.game_over), 0);
    cyc();
    chk("normal_game_over", int'(bus.game_over), 1);
    chk("normal_points", int'(bus.total_points), 10);
    chk("normal_misses", int'(bus.misses), 15);
    // same-light corner cases
    restart(4'b0001, 0);
    ev(1, 0, 0, 0, 4'd3, 1);
    ev(0, 0, 1, 4'd3, 4'd3, 1);
    ev(0, 0, 1, 4'd3, 4'd3, 1);
    ev(0, 0, 1, 4'd5, 4'd3, 1);
    ev(0, 1, 0, 0, 4'd3, 1);
    ev(1, 0, 0, 0, 4'd7, 1);
    ev(0, 1, 1, 4'd7, 4'd7, 1);
    ev(0, 0, 1, 4'd7, 4'd7, 1);
    ev(1, 0, 0, 0, 4'd2, 1);
    ev(0, 0, 1, 4'd9, 4'd2, 1);
    ev(0, 1, 0, 0, 4'd2, 1);
    chk("same_light_points", int'(bus.total_points), 2);
    chk("same_light_misses", int'(bus.misses), 1);
    bus.gamemode = 4'b0100;
    abort_game();
    ev(1, 0, 0, 0, 4'd4, 0);
    ev(0, 0, 1, 4'd4, 4'd4, 0);
    ev(0, 1, 0, 0, 4'd4, 0);
    // timed mode countdown
    restart(4'b0010, 0);
    chk("timed_difficulty", int'(bus.difficulty_oh), 4'b0100);
    mp = 0; mt = 60;
    while (mt > 0) begin
      cyc();
      if (mp == 3) begin mp = 0; mt--; end else mp++;
      chk("timed_time_left", int'(bus.time_left), mt);
    end
    chk("timed_not_over_yet", int'(bus.game_over), 0);
    cyc();
    chk("timed_game_over", int'(bus.game_over), 1);
    repeat (6) cyc();
    chk("timed_time_sat", int'(bus.time_left), 0);
    // deathmatch
    restart(4'b0100, 0);
    lights(1, 0);
    chk("death_hit_no_end", int'(bus.game_over), 0);
    lights(0, 1);
    chk("death_not_over_yet", int'(bus.game_over), 0);
    cyc();
    chk("death_game_over", int'(bus.game_over), 1);
    chk("death_misses", int'(bus.misses), 1);
    // level continuity
    restart(4'b1000, 1);
    chk("level_start_difficulty", int'(bus.difficulty_oh), 4'b0001);
    for (int i = 0; i < 20; i++) begin
      if (i == 8) bus.gamemode = 4'b0010;
      ev(1, 0, 0, 0, 4'(i % 16), 1);
      ev(0, 0, 1, 4'(i % 16), 4'(i % 16), 1);
      lvl = m_points / 5 > 3 ? 3 : m_points / 5;
      chk("level_difficulty", int'(bus.difficulty_oh), 1 << lvl);
      ev(0, 1, 0, 0, 4'(i % 16), 1);
    end
    chk("level_still_playing", int'(bus.start_game), 1);
    abort_game();
    chk("level_frozen_points", int'(bus.total_points), 20);
`ifdef BEST_SCORE_EN
    chk("best_after_level", int'(bus.best_score), 20);
    reset = 1'b0;
    #1;
    chk("best_reset", int'(bus.best_score), 0);
    bus.gamemode = 4'b0001; bus.extended = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    start_from_setup();
    lights(7, 0);
    abort_game();
    chk("best_first_game", int'(bus.best_score), 7);
    restart(4'b0001, 0);
    chk("best_kept_by_restart", int'(bus.best_score), 7);
    lights(4, 0);
    abort_game();
    chk("best_second_game", int'(bus.best_score), 7);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
